// File: rtl/atr_sequencer.sv
// atr_sequencer: half-duplex auto T/R sequencer with programmable turn-on/turn-off delays.
// Optional feature macro ATR_BURST_COUNT_EN adds a counter of TX burst entries.
module atr_sequencer #(
   parameter logic [6:0] BASE    = 7'd48,
   parameter int         DELAY_W = 12
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   input  logic        enable_tx,
   input  logic        tx_empty,
   output logic [15:0] atr_out,
   output logic        tx_active,
   output logic        rx_active,
   output logic [1:0]  atr_state,
   output logic [31:0] tx_burst_count
);
   typedef enum logic [1:0] {RX = 2'd0, TX_WAIT = 2'd1, TX = 2'd2, RX_WAIT = 2'd3} state_t;
   localparam logic [DELAY_W-1:0] ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
   state_t state_q, state_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d, tx_delay_q, tx_delay_d, rx_delay_q, rx_delay_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic [15:0] rxval_q, rxval_d, txval_q, txval_d, atr_out_q, atr_out_d;
   logic tx_active_q, tx_active_d, rx_active_q, rx_active_d;
   logic wr_ctrl, wr_delays, wr_values, enable, force_tx, force_rx, go;
   assign wr_ctrl   = serial_strobe && serial_addr == BASE;
   assign wr_delays = serial_strobe && serial_addr == BASE + 7'd1;
   assign wr_values = serial_strobe && serial_addr == BASE + 7'd2;
   assign enable    = ctrl_q[0];
   assign force_tx  = ctrl_q[1];
   assign force_rx  = ctrl_q[2];
   assign go        = enable && enable_tx && !tx_empty;
   // settings-bus register file
   always_comb begin
      ctrl_d     = wr_ctrl   ? serial_data[2:0] : ctrl_q;
      tx_delay_d = wr_delays ? serial_data[DELAY_W-1:0] : tx_delay_q;
      rx_delay_d = wr_delays ? serial_data[16+DELAY_W-1:16] : rx_delay_q;
      rxval_d    = wr_values ? serial_data[15:0] : rxval_q;
      txval_d    = wr_values ? serial_data[31:16] : txval_q;
   end
   // next state: forces first, then enable gate, then the delay FSM; outputs follow next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (force_tx) state_d = TX;
      else if (force_rx) state_d = RX;
      else if (!enable) begin
         state_d = RX;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RX: if (go) begin
               state_d = (tx_delay_q == '0) ? TX : TX_WAIT;
               cnt_d   = tx_delay_q;
            end
            TX_WAIT: if (!go) state_d = RX;
               else if (cnt_q == ONE) state_d = TX;
               else cnt_d = cnt_q - ONE;
            TX: if (!go) begin
               state_d = (rx_delay_q == '0) ? RX : RX_WAIT;
               cnt_d   = rx_delay_q;
            end
            RX_WAIT: if (go) state_d = TX;
               else if (cnt_q == ONE) state_d = RX;
               else cnt_d = cnt_q - ONE;
         endcase
      end
      atr_out_d   = (state_d == RX) ? rxval_q : txval_q;
      tx_active_d = state_d == TX;
      rx_active_d = (state_d == RX) && (enable || force_rx);
   end
   // state, counter, registers and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RX;
         cnt_q       <= '0;
         ctrl_q      <= '0;
         tx_delay_q  <= '0;
         rx_delay_q  <= '0;
         rxval_q     <= '0;
         txval_q     <= '0;
         atr_out_q   <= '0;
         tx_active_q <= 1'b0;
         rx_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ctrl_q      <= ctrl_d;
         tx_delay_q  <= tx_delay_d;
         rx_delay_q  <= rx_delay_d;
         rxval_q     <= rxval_d;
         txval_q     <= txval_d;
         atr_out_q   <= atr_out_d;
         tx_active_q <= tx_active_d;
         rx_active_q <= rx_active_d;
      end
   end
   assign atr_out   = atr_out_q;
   assign tx_active = tx_active_q;
   assign rx_active = rx_active_q;
   assign atr_state = state_q;
`ifdef ATR_BURST_COUNT_EN
   logic [31:0] burst_q, burst_d;
   logic        burst_inc;
   // count FSM entries into TX from RX or TX_WAIT; a ctrl write clears the count
   always_comb begin
      burst_inc = !force_tx && state_d == TX && (state_q == RX || state_q == TX_WAIT);
      burst_d   = wr_ctrl ? 32'd0 : burst_q + 32'(burst_inc);
   end
   // burst counter register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) burst_q <= '0;
      else burst_q <= burst_d;
   end
   assign tx_burst_count = burst_q;
`else
   assign tx_burst_count = 32'd0;
`endif
endmodule

// File: tb/tb_atr_sequencer.sv
// tb_atr_sequencer: scoreboard bench for atr_sequencer
module tb_atr_sequencer;
   localparam logic [6:0] BASE = 7'd48;
   logic clock = 1'b0, reset_n = 1'b0, serial_strobe = 1'b0, enable_tx = 1'b0, tx_empty = 1'b1;
   logic [6:0] serial_addr = '0;
   logic [31:0] serial_data = '0;
   logic [15:0] atr_out;
   logic tx_active, rx_active;
   logic [1:0] atr_state;
   logic [31:0] tx_burst_count;
   int n_cmp = 0, n_bad = 0, edge_n = 0, nb = 0;
   typedef struct {
      int          cyc;
      string       tag;
      logic [1:0]  st;
      logic [15:0] out;
      logic        ta;
      logic        ra;
      logic [31:0] bc;
   } exp_t;
   exp_t sb[$];
   atr_sequencer dut (
      .clock(clock), .reset_n(reset_n), .serial_addr(serial_addr), .serial_data(serial_data),
      .serial_strobe(serial_strobe), .enable_tx(enable_tx), .tx_empty(tx_empty), .atr_out(atr_out),
      .tx_active(tx_active), .rx_active(rx_active), .atr_state(atr_state), .tx_burst_count(tx_burst_count)
   );
   always #5 clock = ~clock;
   always @(posedge clock) edge_n++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, want, edge_n);
      end
   endtask
   function automatic logic [31:0] bx();
`ifdef ATR_BURST_COUNT_EN
      return 32'(nb);
`else
      return 32'd0;
`endif
   endfunction
   task automatic ex(input int d, input string tag, input logic [1:0] st, input logic [15:0] o,
                     input logic ta, input logic ra);
      exp_t e;
      e.cyc = edge_n + d; e.tag = tag; e.st = st; e.out = o; e.ta = ta; e.ra = ra; e.bc = bx();
      sb.push_back(e);
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      serial_addr = a; serial_data = d; serial_strobe = 1'b1;
      tick(1);
      serial_strobe = 1'b0;
   endtask
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, "_cyc"}, edge_n, e.cyc);
         chk({e.tag, "_st"}, atr_state, e.st);
         chk({e.tag, "_out"}, atr_out, e.out);
         chk({e.tag, "_txa"}, tx_active, e.ta);
         chk({e.tag, "_rxa"}, rx_active, e.ra);
         chk({e.tag, "_bc"}, tx_burst_count, e.bc);
      end
   end
   initial begin
      repeat (4) begin
         @(posedge clock); #1;
         serial_addr = 7'($urandom); serial_data = $urandom; serial_strobe = 1'($urandom);
         enable_tx = 1'($urandom); tx_empty = 1'($urandom);
      end
      #3;
      chk("rst_out", atr_out, 0);
      chk("rst_st", atr_state, 0);
      chk("rst_txa", tx_active, 0);
      chk("rst_rxa", rx_active, 0);
      chk("rst_bc", tx_burst_count, 0);
      serial_strobe = 1'b0; enable_tx = 1'b1; tx_empty = 1'b1;
      reset_n = 1'b1;
      tick(2);
      ex(0, "rel", 0, 16'h0, 0, 0);
      wr(BASE + 7'd1, 32'h0005_0003);
      wr(BASE + 7'd2, 32'hA5A5_5A5A);
      wr(BASE, 32'h1);
      nb = 0;
      tick(1);
      ex(0, "t2_idle", 0, 16'h5A5A, 0, 1);
      tx_empty = 1'b0;
      for (int d = 1; d <= 3; d++) ex(d, "t2_txw", 1, 16'hA5A5, 0, 0);
      nb++;
      ex(4, "t2_tx", 2, 16'hA5A5, 1, 0);
      tick(6);
      tx_empty = 1'b1;
      for (int d = 1; d <= 5; d++) ex(d, "t2_rxw", 3, 16'hA5A5, 0, 0);
      ex(6, "t2_rx", 0, 16'h5A5A, 0, 1);
      tick(6);
      wr(BASE + 7'd2, 32'h1234_00FF);
      ex(0, "val_old", 0, 16'h5A5A, 0, 1);
      ex(1, "val_new", 0, 16'h00FF, 0, 1);
      tick(1);
      wr(BASE + 7'd1, 32'h0);
      for (int b = 0; b < 4; b++) begin
         tx_empty = 1'b0;
         nb++;
         for (int d = 1; d <= 4; d++) ex(d, "t3_tx", 2, 16'h1234, 1, 0);
         tick(4);
         tx_empty = 1'b1;
         for (int d = 1; d <= 4; d++) ex(d, "t3_rx", 0, 16'h00FF, 0, 1);
         tick(4);
      end
      wr(BASE + 7'd1, 32'h0000_000A);
      tx_empty = 1'b0;
      for (int d = 1; d <= 4; d++) ex(d, "t4_txw", 1, 16'h1234, 0, 0);
      tick(4);
      tx_empty = 1'b1;
      ex(1, "t4_rx", 0, 16'h00FF, 0, 1);
      ex(2, "t4_rx2", 0, 16'h00FF, 0, 1);
      tick(2);
      wr(BASE + 7'd1, 32'h0008_0000);
      tx_empty = 1'b0;
      nb++;
      ex(1, "t5_tx", 2, 16'h1234, 1, 0);
      ex(2, "t5_tx2", 2, 16'h1234, 1, 0);
      tick(2);
      tx_empty = 1'b1;
      for (int d = 1; d <= 4; d++) ex(d, "t5_rxw", 3, 16'h1234, 0, 0);
      tick(4);
      tx_empty = 1'b0;
      ex(1, "t5_back", 2, 16'h1234, 1, 0);
      ex(2, "t5_back2", 2, 16'h1234, 1, 0);
      tick(2);
      wr(BASE + 7'd1, 32'h0000_0003);
      tx_empty = 1'b1;
      ex(1, "sim_rx", 0, 16'h00FF, 0, 1);
      tick(2);
      tx_empty = 1'b0;
      for (int d = 1; d <= 3; d++) ex(d, "sim_txw", 1, 16'h1234, 0, 0);
      tick(3);
      tx_empty = 1'b1;
      ex(1, "sim_abort", 0, 16'h00FF, 0, 1);
      ex(2, "sim_abort2", 0, 16'h00FF, 0, 1);
      tick(2);
      wr(BASE, 32'h2);
      nb = 0;
      ex(1, "ftx", 2, 16'h1234, 1, 0);
      tick(2);
      wr(BASE, 32'h0);
      ex(1, "dis", 0, 16'h00FF, 0, 0);
      tick(2);
      wr(BASE, 32'h4);
      ex(1, "frx", 0, 16'h00FF, 0, 1);
      tick(2);
      wr(BASE, 32'h6);
      ex(1, "fprio", 2, 16'h1234, 1, 0);
      tick(2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out", atr_out, 0);
      chk("arst_st", atr_state, 0);
      chk("arst_txa", tx_active, 0);
      chk("arst_rxa", rx_active, 0);
      chk("arst_bc", tx_burst_count, 0);
      chk("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
